// File: rtl/obi_host_mem_arbiter.sv
// rtl/obi_host_mem_arbiter.sv - round-robin OBI arbiter onto one host-memory port
// Responses return in grant order, routed through a requester-ID FIFO.
module obi_host_mem_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ*DATA_W/8-1:0]   be_i,
  input  logic [NUM_REQ*ADDR_W-1:0]     addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]     wdata_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [NUM_REQ*DATA_W-1:0]     rdata_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [DATA_W/8-1:0]           mem_be_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [DATA_W-1:0]             mem_wdata_o,
  input  logic                          mem_gnt_i,
  input  logic                          mem_rvalid_i,
  input  logic [DATA_W-1:0]             mem_rdata_i
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = $clog2(MAX_OUTST);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [ID_W-1:0]  locked_id_q, locked_id_d;
  logic [ID_W-1:0]  fifo_q [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic [ID_W-1:0]  rr_sel, cand, sel, head;
  logic             found, full, empty, grant, push, pop;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    rr_sel = rr_ptr_q;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        rr_sel = cand;
        found  = 1'b1;
      end
    end
  end

  assign sel       = lock_q ? locked_id_q : rr_sel;
  assign full      = (count_q == CNT_W'(MAX_OUTST));
  assign empty     = (count_q == '0);
  assign mem_req_o = req_i[sel] & ~full;
  assign grant     = mem_req_o & mem_gnt_i;
  assign push      = grant;
  assign head      = fifo_q[rd_ptr_q];
  assign pop       = mem_rvalid_i & ~empty;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (mem_req_o && (32'(sel) == i)) begin
        mem_we_o    = we_i[i];
        mem_be_o    = be_i[i*BE_W +: BE_W];
        mem_addr_o  = addr_i[i*ADDR_W +: ADDR_W];
        mem_wdata_o = wdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign gnt_o    = grant ? (NUM_REQ'(1) << sel) : '0;
  assign rvalid_o = pop ? (NUM_REQ'(1) << head) : '0;
  assign rdata_o  = {NUM_REQ{mem_rdata_i}};

  // Lock keeps the address phase stable while memory withholds the grant.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    if (grant) begin
      rr_ptr_d = (32'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
      lock_d   = 1'b0;
    end else if (mem_req_o) begin
      lock_d      = 1'b1;
      locked_id_d = sel;
    end else if (lock_q && !req_i[locked_id_q]) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      locked_id_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int unsigned i = 0; i < MAX_OUTST; i++) fifo_q[i] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  a_rvalid_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> !empty)
    else $warning("obi_host_mem_arbiter: response with nothing outstanding dropped");

  a_locked_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> req_i[locked_id_q])
    else $warning("obi_host_mem_arbiter: locked requester withdrew req before grant");

endmodule

// File: tb/tb_obi_host_mem_arbiter.sv
// tb/tb_obi_host_mem_arbiter.sv - scoreboard bench for obi_host_mem_arbiter
module tb_obi_host_mem_arbiter;
  localparam int NR = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NR-1:0]     req_i, we_i;
  logic [NR*4-1:0]   be_i;
  logic [NR*32-1:0]  addr_i, wdata_i;
  logic [NR-1:0]     gnt_o, rvalid_o;
  logic [NR*32-1:0]  rdata_o;
  logic              mem_req_o, mem_we_o;
  logic [3:0]        mem_be_o;
  logic [31:0]       mem_addr_o, mem_wdata_o;
  logic              mem_gnt_i, mem_rvalid_i;
  logic [31:0]       mem_rdata_i;

  obi_host_mem_arbiter #(.NUM_REQ(NR), .MAX_OUTST(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int id; logic [31:0] val; } exp_t;
  exp_t exp_gnt_q[$];
  exp_t exp_rsp_q[$];
  logic [31:0] mem [logic [31:0]];
  int checks = 0;
  int errors = 0;
  int drain_ids[4] = '{3, 0, 1, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
    req_i[i]          = 1'b1;
    we_i[i]           = we;
    be_i[i*4 +: 4]    = 4'hF;
    addr_i[i*32 +: 32]  = a;
    wdata_i[i*32 +: 32] = d;
  endtask

  task automatic clr_req(input int i);
    req_i[i] = 1'b0;
  endtask

  task automatic clear_all();
    req_i = '0; we_i = '0; be_i = '0; addr_i = '0; wdata_i = '0;
  endtask

  task automatic exp_g(input int id, input logic [31:0] a);
    exp_t e;
    e.id = id; e.val = a;
    exp_gnt_q.push_back(e);
  endtask

  task automatic exp_r(input int id, input logic [31:0] d);
    exp_t e;
    e.id = id; e.val = d;
    exp_rsp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    cyc();
    cyc();
    rst_ni = 1'b1;
  endtask

  // Monitor: every grant and every response is matched against the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (gnt_o != '0) begin
        if (exp_gnt_q.size() == 0) check("gnt_unexpected", gnt_o, 0);
        else begin
          exp_t e;
          e = exp_gnt_q.pop_front();
          check("gnt_id", gnt_o, 64'(4'b0001 << e.id));
          check("gnt_addr", mem_addr_o, e.val);
        end
      end
      if (rvalid_o != '0) begin
        if (exp_rsp_q.size() == 0) check("rsp_unexpected", rvalid_o, 0);
        else begin
          exp_t e;
          e = exp_rsp_q.pop_front();
          check("rsp_id", rvalid_o, 64'(4'b0001 << e.id));
          check("rsp_data", rdata_o[e.id*32 +: 32], e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_all();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("rst_gnt", gnt_o, 0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_we", mem_we_o, 0);
    check("rst_mem_be", mem_be_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_wdata", mem_wdata_o, 0);
    cyc();
    rst_ni = 1'b1;
    cyc();

    // single write from requester 0, then read it back through requester 1
    set_req(0, 1'b1, 32'h0003_0000, 32'hDEAD_BEEF);
    mem_gnt_i = 1'b1;
    exp_g(0, 32'h0003_0000);
    mem[32'h0003_0000] = 32'hDEAD_BEEF;
    @(negedge clk_i);
    check("wr_gnt", gnt_o, 4'b0001);
    check("wr_we", mem_we_o, 1);
    check("wr_be", mem_be_o, 4'hF);
    check("wr_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    cyc();
    clear_all(); mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0;
    exp_r(0, 32'h0);
    @(negedge clk_i);
    check("wr_rvalid", rvalid_o, 4'b0001);
    cyc();
    mem_rvalid_i = 1'b0;
    set_req(1, 1'b0, 32'h0003_0000, 32'h0);
    mem_gnt_i = 1'b1;
    exp_g(1, 32'h0003_0000);
    cyc();
    clear_all(); mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = mem[32'h0003_0000];
    exp_r(1, 32'hDEAD_BEEF);
    cyc();
    mem_rvalid_i = 1'b0;

    // all four requesting continuously: strict rotation from 0
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'h1000 + i*4, 32'h0);
    mem_gnt_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      exp_g(c % 4, 32'h1000 + (c % 4) * 4);
      if (c > 0) begin
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h100 + c;
        exp_r((c - 1) % 4, 32'h100 + c);
      end
      cyc();
    end
    clear_all(); mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h108;
    exp_r(3, 32'h108);
    cyc();
    mem_rvalid_i = 1'b0;

    // lock: requester 2 waits three cycles, requester 0 joins in cycle 2
    set_req(2, 1'b0, 32'h2222_0000, 32'h0);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) set_req(0, 1'b0, 32'h0000_5000, 32'h0);
      @(negedge clk_i);
      check("lock_addr", mem_addr_o, 32'h2222_0000);
      check("lock_req", mem_req_o, 1);
      cyc();
    end
    mem_gnt_i = 1'b1;
    exp_g(2, 32'h2222_0000);
    cyc();
    clr_req(2);
    exp_g(0, 32'h0000_5000);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h3002;
    exp_r(2, 32'h3002);
    cyc();
    clear_all(); mem_gnt_i = 1'b0;
    mem_rdata_i = 32'h3000;
    exp_r(0, 32'h3000);
    cyc();
    mem_rvalid_i = 1'b0;

    // outstanding limit, full release timing, same-cycle push and pop at count 3
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'h4000 + i*16, 32'h0);
    mem_gnt_i = 1'b1;
    exp_g(1, 32'h4010); cyc();
    exp_g(2, 32'h4020); cyc();
    exp_g(3, 32'h4030); cyc();
    exp_g(0, 32'h4000); cyc();
    @(negedge clk_i);
    check("full_blocks", mem_req_o, 0);
    cyc();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h500;
    exp_r(1, 32'h500);
    @(negedge clk_i);
    check("full_on_pop_cycle", mem_req_o, 0);
    cyc();
    mem_rdata_i = 32'h600;
    exp_r(2, 32'h600);
    exp_g(1, 32'h4010);
    @(negedge clk_i);
    check("fifth_req", mem_req_o, 1);
    cyc();
    mem_rvalid_i = 1'b0;
    clr_req(1); clr_req(2); clr_req(3);
    exp_g(0, 32'h4000);
    cyc();
    @(negedge clk_i);
    check("full_after_push_pop", mem_req_o, 0);
    cyc();
    clear_all(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_rdata_i = 32'h900 + k;
      exp_r(drain_ids[k], 32'h900 + k);
      cyc();
    end
    mem_rvalid_i = 1'b0;

    // reset with two outstanding, stale responses dropped, rr restarts at 0
    set_req(1, 1'b0, 32'h6010, 32'h0);
    set_req(2, 1'b0, 32'h6020, 32'h0);
    mem_gnt_i = 1'b1;
    exp_g(1, 32'h6010); cyc();
    clr_req(1);
    exp_g(2, 32'h6020); cyc();
    clear_all(); mem_gnt_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("midrst_mem_req", mem_req_o, 0);
    check("midrst_gnt", gnt_o, 0);
    cyc(); cyc();
    rst_ni = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_0000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      check("flushed_rvalid", rvalid_o, 0);
      cyc();
    end
    mem_rvalid_i = 1'b0;
    set_req(1, 1'b0, 32'h7010, 32'h0);
    set_req(3, 1'b0, 32'h7030, 32'h0);
    mem_gnt_i = 1'b1;
    exp_g(1, 32'h7010);
    @(negedge clk_i);
    check("rr_after_reset", gnt_o, 4'b0010);
    cyc();
    clear_all(); mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777;
    exp_r(1, 32'h7777);
    cyc();
    mem_rvalid_i = 1'b0;
    cyc();

    check("gnt_queue_drained", exp_gnt_q.size(), 0);
    check("rsp_queue_drained", exp_rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
